// File: rtl/rom_text_reader_if.sv
// ROM read port plus character stream towards the Morse encoder.
// master = reader side, slave = ROM/encoder side.
interface rom_text_reader_if #(
  parameter int unsigned ADR_W = 17
) ();
  logic             rom_cs;
  logic [ADR_W-1:0] rom_adr;
  logic [7:0]       rom_data;
  logic [7:0]       char_data;
  logic             char_valid;
  logic             char_ready;

  modport master (
    output rom_cs, rom_adr, char_data, char_valid,
    input  rom_data, char_ready
  );

  modport slave (
    input  rom_cs, rom_adr, char_data, char_valid,
    output rom_data, char_ready
  );
endinterface

// File: rtl/rom_text_reader.sv
// Walks the text ROM from BASE_ADR and streams characters to the Morse encoder.
// Optional macro TEXT_UPCASE_EN folds 'a'..'z' to upper case before emission.
module rom_text_reader #(
  parameter int unsigned ADR_W    = 17,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned BASE_ADR = 0,
  parameter logic [7:0]  TERM     = 8'h00,
  parameter int unsigned CNT_W    = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  rom_text_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  char_count
);

  typedef enum logic [2:0] {StIdle, StFetch, StCapt, StSend, StDone} state_e;

  localparam logic [ADR_W-1:0] AdrBase = ADR_W'(BASE_ADR);
  localparam logic [ADR_W-1:0] AdrLast = ADR_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic             rom_cs_q, rom_cs_d;
  logic [ADR_W-1:0] rom_adr_q, rom_adr_d;
  logic [7:0]       char_data_q, char_data_d;
  logic             char_valid_q, char_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] char_count_q, char_count_d;
  logic [7:0]       char_byte;

  always_comb begin
`ifdef TEXT_UPCASE_EN
    if (bus.rom_data >= 8'h61 && bus.rom_data <= 8'h7a) begin
      char_byte = bus.rom_data - 8'h20;
    end else begin
      char_byte = bus.rom_data;
    end
`else
    char_byte = bus.rom_data;
`endif
  end

  always_comb begin
    state_d      = state_q;
    rom_cs_d     = rom_cs_q;
    rom_adr_d    = rom_adr_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    char_count_d = char_count_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          rom_adr_d    = AdrBase;
          char_count_d = '0;
          busy_d       = 1'b1;
          rom_cs_d     = 1'b1;
          state_d      = StFetch;
        end
      end
      StFetch: state_d = StCapt;
      StCapt: begin
        // Terminator test is on the raw ROM byte, before any case folding.
        if (bus.rom_data == TERM) begin
          state_d = StDone;
        end else begin
          char_data_d  = char_byte;
          char_valid_d = 1'b1;
          state_d      = StSend;
        end
      end
      StSend: begin
        if (char_ready_hs()) begin
          char_valid_d = 1'b0;
          char_count_d = char_count_q + CNT_W'(1);
          if (rom_adr_q == AdrLast) begin
            state_d = StDone;
          end else begin
            rom_adr_d = rom_adr_q + ADR_W'(1);
            state_d   = StFetch;
          end
        end
      end
      StDone: begin
        rom_cs_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything outside idle, including a pending handshake.
    if (abort && state_q != StIdle) begin
      state_d      = StIdle;
      char_valid_d = 1'b0;
      rom_cs_d     = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      char_count_d = char_count_q;
    end
  end

  function automatic logic char_ready_hs();
    return bus.char_ready && char_valid_q;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rom_cs_q     <= 1'b0;
      rom_adr_q    <= AdrBase;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      char_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rom_cs_q     <= rom_cs_d;
      rom_adr_q    <= rom_adr_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      char_count_q <= char_count_d;
    end
  end

  assign bus.rom_cs     = rom_cs_q;
  assign bus.rom_adr    = rom_adr_q;
  assign bus.char_data  = char_data_q;
  assign bus.char_valid = char_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign char_count     = char_count_q;

endmodule

// File: tb/tb_rom_text_reader.sv
// Bench for rom_text_reader: vector table, hand sequences for abort/reset/end-of-ROM,
// and randomized messages checked against a ROM-scanning reference model.
module tb_rom_text_reader;
  localparam int unsigned ADR_W    = 17;
  localparam int unsigned DEPTH    = 4096;
  localparam int unsigned BASE_ADR = 0;
  localparam int unsigned CNT_W    = 13;
  localparam logic [7:0]  TERM     = 8'h00;
  localparam logic [ADR_W-1:0] LastAdr = ADR_W'(DEPTH - 1);

`ifdef TEXT_UPCASE_EN
  localparam logic [63:0] ExpSos = 64'h0000_0000_0053_4F53;
  localparam logic [63:0] ExpMix = 64'h0000_4160_7B5A_4948;
`else
  localparam logic [63:0] ExpSos = 64'h0000_0000_0073_6F73;
  localparam logic [63:0] ExpMix = 64'h0000_6160_7B7A_6948;
`endif

  typedef struct {
    logic [63:0] msg;
    int          len;
    int          stall_idx;
    int          stall_cyc;
    int          exp_cnt;
    logic [63:0] exp_chars;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic [CNT_W-1:0] char_count;

  rom_text_reader_if #(.ADR_W(ADR_W)) bus ();

  rom_text_reader #(
    .ADR_W(ADR_W), .DEPTH(DEPTH), .BASE_ADR(BASE_ADR), .TERM(TERM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus.master),
    .busy(busy), .done(done), .char_count(char_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:DEPTH-1];
  always @(posedge clk)
    bus.rom_data <= (bus.rom_cs && bus.rom_adr <= LastAdr) ? mem[bus.rom_adr[11:0]] : 8'h00;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes, valid rises, done pulses, address range.
  logic [7:0] got_q [$];
  int rise_q [$];
  int done_cnt = 0;
  int done_cyc = 0;
  int adr_over = 0;
  logic [ADR_W-1:0] max_adr = '0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.char_valid && !prev_valid) rise_q.push_back(cyc);
      if (bus.char_valid && bus.char_ready && !abort) got_q.push_back(bus.char_data);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.rom_adr > LastAdr) adr_over <= adr_over + 1;
      if (bus.rom_adr > max_adr) max_adr <= bus.rom_adr;
      prev_valid <= bus.char_valid;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [7:0] ref_char(input logic [7:0] b);
`ifdef TEXT_UPCASE_EN
    if (b >= "a" && b <= "z") return b - ("a" - "A");
`endif
    return b;
  endfunction

  task automatic load(input logic [63:0] msg, input int len);
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h41;
    for (int i = 0; i < len; i++) mem[BASE_ADR + i] = msg[8*i +: 8];
    mem[BASE_ADR + len] = TERM;
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int g0, r0, d0, s, bad;
    logic [ADR_W-1:0] adr_hold;
    load(v.msg, v.len);
    g0 = got_q.size(); r0 = rise_q.size(); d0 = done_cnt;
    bus.char_ready = 1'b1;
    pulse_start(s);
    check("busy_after_start", busy, 1);
    check("cs_after_start", bus.rom_cs, 1);
    if (v.stall_idx >= 0) begin
      for (int i = 0; i < 200 && got_q.size() - g0 < v.stall_idx; i++) begin
        @(posedge clk); #1;
      end
      bus.char_ready = 1'b0;
      for (int i = 0; i < 20 && !bus.char_valid; i++) begin
        @(posedge clk); #1;
      end
      adr_hold = bus.rom_adr;
      bad = 0;
      repeat (v.stall_cyc) begin
        @(posedge clk); #1;
        if (!bus.char_valid || bus.char_data != v.exp_chars[8*v.stall_idx +: 8] ||
            bus.rom_adr != adr_hold) bad++;
      end
      check("stall_hold", bad, 0);
      check("stall_adr", bus.rom_adr, BASE_ADR + v.stall_idx);
      bus.char_ready = 1'b1;
    end
    wait_done(300, d0);
    check("char_total", got_q.size() - g0, v.exp_cnt);
    bad = 0;
    for (int k = 0; k < v.exp_cnt; k++)
      if (got_q.size() <= g0 + k || got_q[g0 + k] != v.exp_chars[8*k +: 8]) bad++;
    check("char_seq", bad, 0);
    check("char_count", char_count, v.exp_cnt);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_end", busy, 0);
    check("cs_end", bus.rom_cs, 0);
    if (v.stall_idx < 0) begin
      bad = 0;
      for (int k = 0; k < v.exp_cnt; k++)
        if (rise_q.size() <= r0 + k || rise_q[r0 + k] - s != 2 + 3 * k) bad++;
      check("valid_timing", bad, 0);
      check("done_timing", done_cyc - s, 3 * v.exp_cnt + 3);
    end
  endtask

  vec_t vecs [5];

  initial begin
    int s, g0, d0, bad;
    logic [7:0] exp_q [$];

    vecs[0] = '{msg: 64'h534F53, len: 3, stall_idx: -1, stall_cyc: 0, exp_cnt: 3,
                exp_chars: 64'h534F53};
    vecs[1] = '{msg: 64'h534F53, len: 3, stall_idx: 1, stall_cyc: 5, exp_cnt: 3,
                exp_chars: 64'h534F53};
    vecs[2] = '{msg: 64'h0, len: 0, stall_idx: -1, stall_cyc: 0, exp_cnt: 0,
                exp_chars: 64'h0};
    vecs[3] = '{msg: 64'h736F73, len: 3, stall_idx: -1, stall_cyc: 0, exp_cnt: 3,
                exp_chars: ExpSos};
    vecs[4] = '{msg: 64'h6160_7B7A_6948, len: 6, stall_idx: 0, stall_cyc: 2, exp_cnt: 6,
                exp_chars: ExpMix};

    bus.char_ready = 1'b0;
    #12;
    check("rst_cs", bus.rom_cs, 0);
    check("rst_adr", bus.rom_adr, BASE_ADR);
    check("rst_data", bus.char_data, 0);
    check("rst_valid", bus.char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", char_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start+abort together in idle: abort wins.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_cs", bus.rom_cs, 0);

    // Second start while busy is ignored.
    load(64'h534F53, 3);
    g0 = got_q.size(); d0 = done_cnt;
    bus.char_ready = 1'b1;
    pulse_start(s);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, d0);
    check("restart_ignored_total", got_q.size() - g0, 3);
    check("restart_ignored_done", done_cnt - d0, 1);

    // Abort during SEND of the second character.
    g0 = got_q.size(); d0 = done_cnt;
    pulse_start(s);
    for (int i = 0; i < 50 && got_q.size() - g0 < 1; i++) begin
      @(posedge clk); #1;
    end
    bus.char_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.char_valid; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_valid", bus.char_valid, 0);
    check("abort_cs", bus.rom_cs, 0);
    check("abort_busy", busy, 0);
    check("abort_count", char_count, 1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    bus.char_ready = 1'b1;
    g0 = got_q.size(); d0 = done_cnt;
    pulse_start(s);
    check("abort_restart_adr", bus.rom_adr, BASE_ADR);
    wait_done(100, d0);
    check("abort_restart_total", got_q.size() - g0, 3);
    check("abort_restart_first", got_q.size() > g0 ? got_q[g0] : 8'h00, 8'h53);

    // Asynchronous reset in mid-message.
    bus.char_ready = 1'b0;
    pulse_start(s);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.char_valid, 0);
    check("mid_rst_cs", bus.rom_cs, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", bus.char_data, 0);
    check("mid_rst_count", char_count, 0);
    check("mid_rst_adr", bus.rom_adr, BASE_ADR);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.char_ready = 1'b1;

    // End of ROM with no terminator.
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h41;
    g0 = got_q.size(); d0 = done_cnt;
    pulse_start(s);
    wait_done(3 * DEPTH + 50, d0);
    check("eor_total", got_q.size() - g0, DEPTH);
    check("eor_count", char_count, DEPTH);
    check("eor_done", done_cnt - d0, 1);
    check("eor_last_adr", bus.rom_adr, DEPTH - 1);
    check("eor_max_adr", max_adr, DEPTH - 1);
    check("eor_no_wrap", adr_over, 0);

    // Random messages, random char_ready, compared against a ROM scan.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(0, 30);
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom_range(1, 255));
      mem[BASE_ADR + len] = TERM;
      exp_q.delete();
      for (int a = BASE_ADR; a < DEPTH && mem[a] != TERM; a++) exp_q.push_back(ref_char(mem[a]));
      g0 = got_q.size(); d0 = done_cnt;
      pulse_start(s);
      for (int i = 0; i < 600 && done_cnt == d0; i++) begin
        @(posedge clk); #1;
        bus.char_ready = 1'($urandom_range(0, 1));
      end
      bus.char_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rand_total", got_q.size() - g0, exp_q.size());
      bad = 0;
      for (int k = 0; k < exp_q.size(); k++)
        if (got_q.size() <= g0 + k || got_q[g0 + k] != exp_q[k]) bad++;
      check("rand_seq", bad, 0);
      check("rand_count", char_count, exp_q.size());
      check("rand_done", done_cnt - d0, 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end
endmodule
